mem_access_master: RTL

- Initiator side of the data-memory interface. Sits in the MEM stage between the pipeline and the byte-array data memory.
- Turns single pipeline load/store requests into data-memory cycles: MemRead, MemWrite, address and 32-bit write data.
- Memory words are big-endian: byte at offset 0 is bits [31:24].
- Adds byte loads (zero-extended) and byte stores. Byte stores are done as read-modify-write, because the memory only writes whole words.
- Asserts freeze to stall the pipeline while a transfer is in flight.

---
 rtl/mem_access_master_pkg.sv | 31 +++
 rtl/mem_access_master_if.sv | 53 +++++
 rtl/mem_access_master_byte_lane_merge.sv | 44 ++++
 rtl/mem_access_master.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mem_access_master_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_master_pkg
// Purpose  : Shared definitions for the MEM-stage data-memory master:
//            bus widths, FSM state encodings, default wait-cycle count and
//            a word-alignment helper.
// Options  : MEM_ALIGN_CHECK_EN (consumed by the interface and top level)
// Revision : 1.0 - initial release
// ============================================================================
package mem_access_master_pkg;

  localparam int ADDRESS_LEN     = 32;
  localparam int INSTRUCTION_LEN = 32;
  localparam logic ENABLE        = 1'b1;

  // Default number of cycles MemRead is held before read data is sampled.
  localparam int MA_WAIT_CYCLES = 1;

  // FSM state encodings, kept as plain 2-bit constants for legacy users.
  localparam logic [1:0] MA_IDLE = 2'd0;
  localparam logic [1:0] MA_RD   = 2'd1;
  localparam logic [1:0] MA_WR   = 2'd2;
  localparam logic [1:0] MA_RESP = 2'd3;

  // Memory cycles always use word-aligned addresses.
  function automatic logic [ADDRESS_LEN-1:0] ma_word_align(input logic [ADDRESS_LEN-1:0] addr);
    return {addr[ADDRESS_LEN-1:2], 2'b00};
  endfunction

endpackage : mem_access_master_pkg
`default_nettype wire

// File: rtl/mem_access_master_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_master_if
// Purpose  : Pipeline request/response channel plus data-memory bus of the
//            MEM-stage master. 'master' is the initiator view, 'slave' the
//            pipeline/memory side view.
// Options  : MEM_ALIGN_CHECK_EN adds the resp_err response flag.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_master_if;
  import mem_access_master_pkg::*;

  // Pipeline request / response
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic                   req_byte;
  logic [ADDRESS_LEN-1:0] req_addr;
  logic [31:0]            req_wdata;
  logic                   resp_valid;
  logic [31:0]            resp_rdata;
  logic                   freeze;
`ifdef MEM_ALIGN_CHECK_EN
  logic                   resp_err;
`endif

  // Data-memory bus
  logic [ADDRESS_LEN-1:0] mem_address;
  logic [31:0]            mem_write_data;
  logic                   mem_read;
  logic                   mem_write;
  logic [31:0]            mem_read_data;

  modport master (
    input  req_valid, req_write, req_byte, req_addr, req_wdata, mem_read_data,
`ifdef MEM_ALIGN_CHECK_EN
    output resp_err,
`endif
    output req_ready, resp_valid, resp_rdata, freeze,
    output mem_address, mem_write_data, mem_read, mem_write
  );

  modport slave (
    output req_valid, req_write, req_byte, req_addr, req_wdata, mem_read_data,
`ifdef MEM_ALIGN_CHECK_EN
    input  resp_err,
`endif
    input  req_ready, resp_valid, resp_rdata, freeze,
    input  mem_address, mem_write_data, mem_read, mem_write
  );

endinterface : mem_access_master_if
`default_nettype wire

// File: rtl/mem_access_master_byte_lane_merge.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_master_byte_lane_merge
// Purpose  : Big-endian byte-lane helper. Replaces the lane selected by
//            lane_i in word_i with byte_i (byte-store merge), and extracts
//            the same lane zero-extended (byte-load result).
//            Lane 0 is bits [31:24], lane 3 is bits [7:0].
// Options  : none
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_master_byte_lane_merge (
  input  logic [31:0] word_i,
  input  logic [7:0]  byte_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] merged_o,
  output logic [31:0] extracted_o
);

  // Lane decode for both the write-merge and the read-extract paths
  always_comb begin
    merged_o    = word_i;
    extracted_o = 32'h0;
    case (lane_i)
      2'b00: begin
        merged_o[31:24]   = byte_i;
        extracted_o[7:0]  = word_i[31:24];
      end
      2'b01: begin
        merged_o[23:16]   = byte_i;
        extracted_o[7:0]  = word_i[23:16];
      end
      2'b10: begin
        merged_o[15:8]    = byte_i;
        extracted_o[7:0]  = word_i[15:8];
      end
      default: begin
        merged_o[7:0]     = byte_i;
        extracted_o[7:0]  = word_i[7:0];
      end
    endcase
  end

endmodule : mem_access_master_byte_lane_merge
`default_nettype wire

// File: rtl/mem_access_master.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_master
// Purpose  : MEM-stage initiator for the byte-array data memory. Converts
//            single pipeline load/store requests into MemRead/MemWrite
//            cycles, performs byte stores as read-modify-write and freezes
//            the pipeline while a transfer is in flight.
// Options  : MEM_ALIGN_CHECK_EN - misaligned word requests skip the memory
//            and complete with resp_err=1.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_master
  import mem_access_master_pkg::*;
#(
  parameter int WAIT_CYCLES = MA_WAIT_CYCLES  // legal range 1..15
) (
  input  logic                 clk,
  input  logic                 rst,          // synchronous, active-low
  mem_access_master_if.master  bus
);

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] WAIT_MAX  = 4'(WAIT_CYCLES);

  logic [1:0]             state_q, state_d;
  logic [ADDRESS_LEN-1:0] addr_q;
  logic [7:0]             wbyte_q;
  logic                   write_q;
  logic                   byte_q;
  logic [31:0]            rbuf_q;
  logic [31:0]            mem_wdata_q;
  logic [3:0]             wait_q;

  logic                   w_accept;
  logic                   w_align_err;
  logic                   w_err_resp;
  logic                   w_rd_last;
  logic [31:0]            w_lane_word;
  logic [31:0]            w_merged;
  logic [31:0]            w_extracted;

  assign w_accept  = (state_q == MA_IDLE) && bus.req_valid;
  assign w_rd_last = (state_q == MA_RD) && (wait_q == WAIT_LAST);

`ifdef MEM_ALIGN_CHECK_EN
  logic err_q;

  assign w_align_err = ~bus.req_byte && (bus.req_addr[1:0] != 2'b00);
  assign w_err_resp  = err_q;

  // Remember whether the accepted request was rejected as misaligned
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_q <= 1'b0;
    end else if (w_accept) begin
      err_q <= w_align_err;
    end
  end

  assign bus.resp_err = (state_q == MA_RESP) && err_q;
`else
  assign w_align_err = 1'b0;
  assign w_err_resp  = 1'b0;
`endif

  // Next-state decode: RD is shared by loads and the read half of byte stores
  always_comb begin
    state_d = state_q;
    case (state_q)
      MA_IDLE: begin
        if (bus.req_valid) begin
          if (w_align_err) begin
            state_d = MA_RESP;
          end else if (!bus.req_write || bus.req_byte) begin
            state_d = MA_RD;
          end else begin
            state_d = MA_WR;
          end
        end
      end
      MA_RD: begin
        if (wait_q == WAIT_LAST) begin
          state_d = write_q ? MA_WR : MA_RESP;
        end
      end
      MA_WR:   state_d = MA_RESP;
      MA_RESP: state_d = MA_IDLE;
      default: state_d = MA_IDLE;
    endcase
  end

  // State register; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MA_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Request latch; rejected requests leave the bus-facing address untouched
  always_ff @(posedge clk) begin
    if (!rst) begin
      addr_q  <= '0;
      wbyte_q <= 8'h0;
      write_q <= 1'b0;
      byte_q  <= 1'b0;
    end else if (w_accept && !w_align_err) begin
      addr_q  <= bus.req_addr;
      wbyte_q <= bus.req_wdata[7:0];
      write_q <= bus.req_write;
      byte_q  <= bus.req_byte;
    end
  end

  // Wait counter: cleared on entry to RD, counts up and saturates at WAIT_CYCLES
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_q <= 4'h0;
    end else if ((state_q != MA_RD) && (state_d == MA_RD)) begin
      wait_q <= 4'h0;
    end else if ((state_q == MA_RD) && (wait_q != WAIT_MAX)) begin
      wait_q <= wait_q + 4'd1;
    end
  end

  // Read buffer captures memory data on the last RD cycle
  always_ff @(posedge clk) begin
    if (!rst) begin
      rbuf_q <= 32'h0;
    end else if (w_rd_last) begin
      rbuf_q <= bus.mem_read_data;
    end
  end

  // Write-data register: word stores load it at accept, byte stores at the
  // end of the read phase with the merged word, so it is stable through WR
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_wdata_q <= 32'h0;
    end else if (w_accept && !w_align_err && bus.req_write && !bus.req_byte) begin
      mem_wdata_q <= bus.req_wdata;
    end else if (w_rd_last && write_q) begin
      mem_wdata_q <= w_merged;
    end
  end

  // During RD the merge sees live memory data; afterwards the captured buffer
  assign w_lane_word = (state_q == MA_RD) ? bus.mem_read_data : rbuf_q;

  mem_access_master_byte_lane_merge u_lane (
    .word_i      (w_lane_word),
    .byte_i      (wbyte_q),
    .lane_i      (addr_q[1:0]),
    .merged_o    (w_merged),
    .extracted_o (w_extracted)
  );

  // Handshake and memory strobes decoded purely from the registered state
  assign bus.req_ready      = (state_q == MA_IDLE);
  assign bus.resp_valid     = (state_q == MA_RESP);
  assign bus.freeze         = (state_q == MA_RD) || (state_q == MA_WR);
  assign bus.mem_read       = (state_q == MA_RD);
  assign bus.mem_write      = (state_q == MA_WR);
  assign bus.mem_address    = ma_word_align(addr_q);
  assign bus.mem_write_data = mem_wdata_q;
  assign bus.resp_rdata     = ((state_q == MA_RESP) && !write_q && !w_err_resp)
                              ? (byte_q ? w_extracted : rbuf_q)
                              : 32'h0;

endmodule : mem_access_master
`default_nettype wire
